// File: rtl/nasti_stream_pkg.sv
// Shared types for the NASTI-stream fabric: arbiter state, port index and
// the round-robin pointer advance helper.
package nasti_stream_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  localparam int MAX_PORT = 4;

  typedef logic [1:0] port_idx_t;

  // Port after p, wrapping at n_port (n_port is 1..MAX_PORT).
  function automatic port_idx_t next_port(input port_idx_t p, input int n_port);
    if (int'(p) + 1 >= n_port) return '0;
    return p + 2'd1;
  endfunction

  // Physical port sitting at rotated position pos when the scan starts at rr.
  function automatic port_idx_t rot_idx(input int pos, input port_idx_t rr);
    return port_idx_t'(pos) + rr;
  endfunction

endpackage

// File: rtl/nasti_stream_reg_slice.sv
// Single-entry stream register. can_accept_o is high when the entry is empty
// or is being drained this cycle, so one beat per cycle flows with ready held.
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// out_valid_o and out_data_o hold stable while out_ready_i is low.
module nasti_stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         can_accept_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Load a new beat whenever there is room; otherwise hold the current one.
  always_comb begin
    can_accept_o = !valid_q || out_ready_i;
    valid_d      = valid_q;
    data_d       = data_q;
    if (can_accept_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  // Entry register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/nasti_stream_arbiter.sv
// Packet-level round-robin merge of up to four NASTI-stream sources into one
// registered output. A granted source keeps the grant until its last beat.
// Handshake: a beat moves on a rising edge where t_valid and t_ready are both
// high; output payload is held stable while slave_t_ready_i is low.
module nasti_stream_arbiter
  import nasti_stream_pkg::*;
#(
  parameter  int N_PORT = 1,
  parameter  int DATA_W = 64,
  parameter  int ID_W   = 1,
  parameter  int DEST_W = 1,
  parameter  int USER_W = 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [MAX_PORT-1:0]              master_t_valid_i,
  output logic [MAX_PORT-1:0]              master_t_ready_o,
  input  logic [MAX_PORT-1:0][DATA_W-1:0]  master_t_data_i,
  input  logic [MAX_PORT-1:0][STRB_W-1:0]  master_t_strb_i,
  input  logic [MAX_PORT-1:0][STRB_W-1:0]  master_t_keep_i,
  input  logic [MAX_PORT-1:0]              master_t_last_i,
  input  logic [MAX_PORT-1:0][ID_W-1:0]    master_t_id_i,
  input  logic [MAX_PORT-1:0][DEST_W-1:0]  master_t_dest_i,
  input  logic [MAX_PORT-1:0][USER_W-1:0]  master_t_user_i,
  output logic                             slave_t_valid_o,
  input  logic                             slave_t_ready_i,
  output logic [DATA_W-1:0]                slave_t_data_o,
  output logic [STRB_W-1:0]                slave_t_strb_o,
  output logic [STRB_W-1:0]                slave_t_keep_o,
  output logic                             slave_t_last_o,
  output logic [ID_W-1:0]                  slave_t_id_o,
  output logic [DEST_W-1:0]                slave_t_dest_o,
  output logic [USER_W-1:0]                slave_t_user_o,
  output arb_state_t                       state_o,
  output port_idx_t                        rr_ptr_o
);

  localparam int PL_W = DATA_W + 2 * STRB_W + 1 + ID_W + DEST_W + USER_W;

  arb_state_t          state_q, state_d;
  port_idx_t           rr_ptr_q, rr_ptr_d;
  port_idx_t           grant_q, grant_d;
  logic [MAX_PORT-1:0] req, req_rot;
  port_idx_t           scan_idx, sel_port;
  logic                scan_hit, sel_valid, sel_last, accept, can_accept;
  logic [PL_W-1:0]     sel_payload, out_payload;

  // Ports at or above N_PORT never request.
  always_comb begin
    req = '0;
    for (int i = 0; i < MAX_PORT; i++) req[i] = master_t_valid_i[i] && (i < N_PORT);
  end

  // Rotate requests so rr_ptr sits at position 0, then take the lowest hit.
  always_comb begin
    req_rot  = '0;
    scan_idx = '0;
    scan_hit = 1'b0;
    for (int i = 0; i < MAX_PORT; i++) req_rot[i] = req[rot_idx(i, rr_ptr_q)];
    for (int i = MAX_PORT - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        scan_hit = 1'b1;
        scan_idx = rot_idx(i, rr_ptr_q);
      end
    end
  end

  // Grant mux: locked packets bypass the scan; ready is withheld during reset.
  always_comb begin
    sel_port    = (state_q == LOCKED) ? grant_q : scan_idx;
    sel_valid   = ((state_q == LOCKED) ? req[grant_q] : scan_hit) && !rst;
    sel_last    = master_t_last_i[sel_port];
    sel_payload = {master_t_data_i[sel_port], master_t_strb_i[sel_port],
                   master_t_keep_i[sel_port], master_t_last_i[sel_port],
                   master_t_id_i[sel_port], master_t_dest_i[sel_port],
                   master_t_user_i[sel_port]};
    accept      = sel_valid && can_accept;
    master_t_ready_o = '0;
    if (!rst && (state_q == LOCKED || scan_hit)) master_t_ready_o[sel_port] = can_accept;
  end

  // Next-state: lock on a non-last beat, release and advance rr_ptr on last.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = next_port(sel_port, N_PORT);
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        grant_d = sel_port;
      end
    end
  end

  // Arbiter state registers; reset restarts arbitration from port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  nasti_stream_reg_slice #(.W(PL_W)) u_slice (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (sel_valid),
    .in_data_i    (sel_payload),
    .can_accept_o (can_accept),
    .out_valid_o  (slave_t_valid_o),
    .out_ready_i  (slave_t_ready_i),
    .out_data_o   (out_payload)
  );

  assign {slave_t_data_o, slave_t_strb_o, slave_t_keep_o, slave_t_last_o,
          slave_t_id_o, slave_t_dest_o, slave_t_user_o} = out_payload;
  assign state_o  = state_q;
  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_nasti_stream_arbiter.sv
// Bench for nasti_stream_arbiter: three instances (N_PORT = 1, 2, 4) share one
// clock and reset and are exercised one at a time.
`timescale 1ns/1ps
module tb_nasti_stream_arbiter;
  import nasti_stream_pkg::*;

  localparam int NI = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       strb;
    logic       keep;
    logic       last;
    logic [1:0] id;
    logic [1:0] dest;
    logic [1:0] user;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    port_idx_t  exp_rr;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      m_valid[NI], m_ready[NI], m_strb[NI], m_keep[NI], m_last[NI];
  logic [3:0][7:0] m_data[NI];
  logic [3:0][1:0] m_id[NI], m_dest[NI], m_user[NI];
  logic            s_valid[NI], s_ready[NI], s_strb[NI], s_keep[NI], s_last[NI];
  logic [7:0]      s_data[NI];
  logic [1:0]      s_id[NI], s_dest[NI], s_user[NI];
  arb_state_t      st[NI];
  port_idx_t       rr[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NP = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    nasti_stream_arbiter #(.N_PORT(NP), .DATA_W(8), .ID_W(2), .DEST_W(2), .USER_W(2)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .master_t_valid_i (m_valid[g]),
      .master_t_ready_o (m_ready[g]),
      .master_t_data_i  (m_data[g]),
      .master_t_strb_i  (m_strb[g]),
      .master_t_keep_i  (m_keep[g]),
      .master_t_last_i  (m_last[g]),
      .master_t_id_i    (m_id[g]),
      .master_t_dest_i  (m_dest[g]),
      .master_t_user_i  (m_user[g]),
      .slave_t_valid_o  (s_valid[g]),
      .slave_t_ready_i  (s_ready[g]),
      .slave_t_data_o   (s_data[g]),
      .slave_t_strb_o   (s_strb[g]),
      .slave_t_keep_o   (s_keep[g]),
      .slave_t_last_o   (s_last[g]),
      .slave_t_id_o     (s_id[g]),
      .slave_t_dest_o   (s_dest[g]),
      .slave_t_user_o   (s_user[g]),
      .state_o          (st[g]),
      .rr_ptr_o         (rr[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- helpers / drivers ----------------
  function automatic int np_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic beat_t mk(input int p, input logic [7:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.strb = d[0];
    b.keep = d[1];
    b.last = last;
    b.id   = 2'(p);
    b.dest = ~2'(p);
    b.user = d[3:2];
    return b;
  endfunction

  function automatic beat_t out_beat(input int k);
    beat_t b;
    b.data = s_data[k];
    b.strb = s_strb[k];
    b.keep = s_keep[k];
    b.last = s_last[k];
    b.id   = s_id[k];
    b.dest = s_dest[k];
    b.user = s_user[k];
    return b;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive(input int k, input int p, input logic v, input beat_t b);
    m_valid[k][p] = v;
    m_data[k][p]  = b.data;
    m_strb[k][p]  = b.strb;
    m_keep[k][p]  = b.keep;
    m_last[k][p]  = b.last;
    m_id[k][p]    = b.id;
    m_dest[k][p]  = b.dest;
    m_user[k][p]  = b.user;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 4; p++) drive(k, p, 1'b0, '0);
      s_ready[k] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reference model: cycle-by-cycle expectation computed from the arbitration
  // rules (owner / round-robin pointer / output occupancy) and a queue of
  // beats that must leave the output in order.
  task automatic run_rand(input int k, input int n_beats);
    int np, owner, mrr, done, cyc, target, acc;
    logic occ, can, sready;
    int rem[4];
    int cnt[4];
    beat_t cur[4];
    logic [16:0] exp_q[$];
    logic [3:0] exp_rdy;
    np = np_of(k); owner = -1; mrr = 0; occ = 1'b0; done = 0; cyc = 0;
    for (int p = 0; p < 4; p++) begin rem[p] = 0; cnt[p] = 0; cur[p] = '0; end
    while (done < n_beats && cyc < 20000) begin
      cyc++;
      for (int p = 0; p < 4; p++) begin
        if (p >= np) begin
          cur[p] = mk(p, 8'($urandom), 1'($urandom));
          drive(k, p, 1'($urandom), cur[p]);
        end else if (!m_valid[k][p] && $urandom_range(0, 2) != 0) begin
          if (rem[p] == 0) rem[p] = $urandom_range(1, 4);
          rem[p]--;
          cur[p] = mk(p, 8'(cnt[p]), rem[p] == 0);
          cnt[p]++;
          drive(k, p, 1'b1, cur[p]);
        end
      end
      sready = ($urandom_range(0, 3) != 0);
      s_ready[k] = sready;
      @(negedge clk);
      can = !occ || sready;
      target = -1;
      if (owner >= 0) target = owner;
      else for (int j = 0; j < np; j++)
        if (target < 0 && m_valid[k][(mrr + j) % np]) target = (mrr + j) % np;
      exp_rdy = (target >= 0 && can) ? 4'(1 << target) : 4'h0;
      chk("rand_ready", m_ready[k], exp_rdy);
      chk("rand_svalid", s_valid[k], occ);
      if (occ && sready) begin
        chk("rand_qdepth", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("rand_beat", out_beat(k), exp_q.pop_front());
      end
      acc = -1;
      if (target >= 0 && can && m_valid[k][target]) begin
        exp_q.push_back(cur[target]);
        done++;
        acc = target;
        if (cur[target].last) begin owner = -1; mrr = (target + 1) % np; end
        else owner = target;
      end
      occ = (acc >= 0) ? 1'b1 : (sready ? 1'b0 : occ);
      step();
      if (acc >= 0) m_valid[k][acc] = 1'b0;
    end
    chk("rand_beats_done", done, n_beats);
    for (int p = 0; p < 4; p++) m_valid[k][p] = 1'b0;
    s_ready[k] = 1'b1;
    @(negedge clk);
    chk("rand_drain_valid", s_valid[k], occ);
    if (occ && exp_q.size() > 0) chk("rand_drain_beat", out_beat(k), exp_q.pop_front());
    step();
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'hF, 4'h1, 2'd1};
    tbl[1]  = '{4'hF, 4'h2, 2'd2};
    tbl[2]  = '{4'hF, 4'h4, 2'd3};
    tbl[3]  = '{4'hF, 4'h8, 2'd0};
    tbl[4]  = '{4'hF, 4'h1, 2'd1};
    tbl[5]  = '{4'h1, 4'h1, 2'd1};
    tbl[6]  = '{4'h8, 4'h8, 2'd0};
    tbl[7]  = '{4'h6, 4'h2, 2'd2};
    tbl[8]  = '{4'h0, 4'h0, 2'd2};
    tbl[9]  = '{4'h5, 4'h4, 2'd3};
    tbl[10] = '{4'h3, 4'h1, 2'd1};
    tbl[11] = '{4'hC, 4'h4, 2'd3};

    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < NI; k++) m_valid[k] = 4'hF;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", m_ready[k], 4'h0);
      chk("rst_svalid", s_valid[k], 1'b0);
      chk("rst_payload", out_beat(k), 17'h0);
      chk("rst_rr", rr[k], 2'd0);
      chk("rst_state", st[k], IDLE);
    end
    idle_all();
    step();
    rst = 1'b0;

    // Table: single-beat packets on the 4-port instance.
    for (int i = 0; i < 12; i++) begin
      for (int p = 0; p < 4; p++) drive(2, p, tbl[i].valid[p], mk(p, 8'((p << 6) | i), 1'b1));
      @(negedge clk);
      chk("tbl_ready", m_ready[2], tbl[i].exp_ready);
      if (i > 0) begin
        chk("tbl_svalid", s_valid[2], tbl[i-1].exp_ready != 4'h0);
        chk("tbl_rr", rr[2], tbl[i-1].exp_rr);
        if (tbl[i-1].exp_ready != 4'h0)
          chk("tbl_beat", out_beat(2),
              mk(oh_idx(tbl[i-1].exp_ready), 8'((oh_idx(tbl[i-1].exp_ready) << 6) | (i - 1)), 1'b1));
      end
      step();
    end
    for (int p = 0; p < 4; p++) m_valid[2][p] = 1'b0;
    @(negedge clk);
    chk("tbl_last_beat", out_beat(2), mk(2, 8'((2 << 6) | 11), 1'b1));
    chk("tbl_last_rr", rr[2], 2'd3);
    step();

    // A: 3-beat packet on port 0 of the 2-port instance.
    drive(1, 0, 1'b1, mk(0, 8'h11, 1'b0));
    @(negedge clk); chk("A_ready", m_ready[1], 4'h1); step();
    drive(1, 0, 1'b1, mk(0, 8'h22, 1'b0));
    @(negedge clk); chk("A_beat1", out_beat(1), mk(0, 8'h11, 1'b0)); chk("A_sv1", s_valid[1], 1'b1);
    chk("A_state", st[1], LOCKED); step();
    drive(1, 0, 1'b1, mk(0, 8'h33, 1'b1));
    @(negedge clk); chk("A_beat2", out_beat(1), mk(0, 8'h22, 1'b0)); step();
    m_valid[1][0] = 1'b0;
    @(negedge clk); chk("A_beat3", out_beat(1), mk(0, 8'h33, 1'b1)); chk("A_sv3", s_valid[1], 1'b1);
    chk("A_rr", rr[1], 2'd1); chk("A_idle", st[1], IDLE); step();
    @(negedge clk); chk("A_empty", s_valid[1], 1'b0); step();

    // B: port 1 requests mid-packet on port 0; no interleave.
    for (int b = 0; b < 4; b++) begin
      drive(1, 0, 1'b1, mk(0, 8'(8'h41 + b), b == 3));
      if (b == 1) drive(1, 1, 1'b1, mk(1, 8'h51, 1'b1));
      @(negedge clk);
      chk("B_ready", m_ready[1], 4'h1);
      if (b > 0) chk("B_beat", out_beat(1), mk(0, 8'(8'h40 + b), 1'b0));
      step();
    end
    m_valid[1][0] = 1'b0;
    @(negedge clk); chk("B_p1_ready", m_ready[1], 4'h2); chk("B_beat_last", out_beat(1), mk(0, 8'h44, 1'b1)); step();
    m_valid[1][1] = 1'b0;
    @(negedge clk); chk("B_p1_beat", out_beat(1), mk(1, 8'h51, 1'b1)); chk("B_rr", rr[1], 2'd0); step();

    // C: output backpressure for 5 cycles mid-packet.
    drive(1, 0, 1'b1, mk(0, 8'h61, 1'b0));
    @(negedge clk); chk("C_ready0", m_ready[1], 4'h1); step();
    drive(1, 0, 1'b1, mk(0, 8'h62, 1'b0));
    s_ready[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("C_hold_valid", s_valid[1], 1'b1);
      chk("C_hold_beat", out_beat(1), mk(0, 8'h61, 1'b0));
      chk("C_hold_ready", m_ready[1], 4'h0);
      step();
    end
    s_ready[1] = 1'b1;
    @(negedge clk); chk("C_resume_ready", m_ready[1], 4'h1); chk("C_beat1", out_beat(1), mk(0, 8'h61, 1'b0)); step();
    drive(1, 0, 1'b1, mk(0, 8'h63, 1'b0));
    @(negedge clk); chk("C_beat2", out_beat(1), mk(0, 8'h62, 1'b0)); step();
    drive(1, 0, 1'b1, mk(0, 8'h64, 1'b1));
    @(negedge clk); chk("C_beat3", out_beat(1), mk(0, 8'h63, 1'b0)); step();
    m_valid[1][0] = 1'b0;
    @(negedge clk); chk("C_beat4", out_beat(1), mk(0, 8'h64, 1'b1)); step();
    @(negedge clk); chk("C_empty", s_valid[1], 1'b0); step();

    // D: reset in the middle of a port-2 packet with rr_ptr=2.
    drive(2, 1, 1'b1, mk(1, 8'h71, 1'b1));
    @(negedge clk); chk("D_pre_ready", m_ready[2], 4'h2); step();
    m_valid[2][1] = 1'b0;
    drive(2, 2, 1'b1, mk(2, 8'h81, 1'b0));
    @(negedge clk); chk("D_rr2", rr[2], 2'd2); chk("D_ready_b1", m_ready[2], 4'h4); step();
    drive(2, 2, 1'b1, mk(2, 8'h82, 1'b0));
    @(negedge clk); chk("D_ready_b2", m_ready[2], 4'h4); step();
    drive(2, 2, 1'b1, mk(2, 8'h83, 1'b0));
    drive(2, 0, 1'b1, mk(0, 8'h91, 1'b1));
    #2 rst = 1'b1;
    #1;
    chk("D_rst_svalid", s_valid[2], 1'b0);
    chk("D_rst_ready", m_ready[2], 4'h0);
    chk("D_rst_rr", rr[2], 2'd0);
    chk("D_rst_state", st[2], IDLE);
    @(negedge clk); chk("D_rst_ready2", m_ready[2], 4'h0);
    rst = 1'b0;
    #1; chk("D_p0_wins", m_ready[2], 4'h1);
    step();
    m_valid[2][0] = 1'b0;
    @(negedge clk); chk("D_p0_beat", out_beat(2), mk(0, 8'h91, 1'b1)); chk("D_p2_ready", m_ready[2], 4'h4); step();
    drive(2, 2, 1'b1, mk(2, 8'h84, 1'b1));
    @(negedge clk); chk("D_rem_beat", out_beat(2), mk(2, 8'h83, 1'b0)); step();
    m_valid[2][2] = 1'b0;
    @(negedge clk); chk("D_rem_last", out_beat(2), mk(2, 8'h84, 1'b1)); chk("D_rr_end", rr[2], 2'd3); step();

    // Randomized runs against the reference model.
    idle_all();
    do_reset(); run_rand(0, 1000);
    do_reset(); run_rand(1, 400);
    do_reset(); run_rand(2, 600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound in case a run stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nasti_stream_arbiter.md
# nasti_stream_arbiter

Packet-level round-robin arbiter that merges up to four NASTI-stream sources into one NASTI-stream sink. It is the inverse companion of the per-port stream slicer: it shares a single downstream stream resource (DMA engine, network port, debug link) between requesters. A source, once granted, keeps the grant until its `t_last` beat is accepted. The output is registered.

## Interface
Parameters:
- `N_PORT`, default 1: number of active inputs, legal range 1..4. Inputs with index >= `N_PORT` are ignored; their `t_ready` is tied to 0.
- Data/strb/keep/id/dest/user widths: taken from the `nasti_stream_channel` interface parameters. All five channels share them.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `master_0..master_3`  `nasti_stream_channel.slave`  interface  input sources; only index [0] of each interface is used.
- `slave`  `nasti_stream_channel.master`  interface  merged output; index [0] is driven.

## Operation
- State `IDLE` (no packet open):
  - Grant goes combinationally to the first valid port found scanning from `rr_ptr` upward, modulo `N_PORT`.
  - The granted port's `t_ready` equals `can_accept`. All other ports see `t_ready=0`.
- Beat accept in `IDLE`:
  - Accepted beat with `t_last=0`: go to `LOCKED`, latch `grant`.
  - Accepted beat with `t_last=1`: stay in `IDLE`; `rr_ptr <= (granted+1) mod N_PORT`.
- State `LOCKED`:
  - Only `grant` sees `t_ready=can_accept`; valids on other ports are ignored.
  - Accepted `t_last=1` beat: go to `IDLE`; `rr_ptr <= (grant+1) mod N_PORT`.
- Output register slice:
  - Single entry. `can_accept = !out_valid || slave.t_ready`.
  - On accept, all fields (`t_data`, `t_strb`, `t_keep`, `t_last`, `t_id`, `t_dest`, `t_user`) are copied unmodified.
  - When `slave.t_ready` is high and nothing is accepted, `out_valid` clears.
- Sustains one beat per cycle when `slave.t_ready=1` continuously.
- Packets from different sources are never interleaved. Beats within a packet keep their order.
- `N_PORT=1`: the arbiter degenerates to a register slice; `rr_ptr` stays 0.
- No timeout: a source that stalls mid-packet holds the grant indefinitely. This is intentional.

## Timing
- Latency: 1 cycle from input accept to `slave.t_valid`.
- Handshake:
  - AXI-stream rules apply. Once `slave.t_valid` is asserted, the payload holds stable until `slave.t_ready`.
  - Input `t_ready` does not depend on that input's own `t_valid` while in `LOCKED`. In `IDLE` it depends on the valids, through the grant.
- Reset values (asynchronous, on `rst` assertion):
  - `slave.t_valid=0`, state=`IDLE`, `rr_ptr=0`, `grant=0`, payload registers 0.
  - While `rst` is high, every `master_i.t_ready=0`.
- Reset mid-packet: the open packet is abandoned. After `rst` deasserts, arbitration restarts from port 0. The remainder of the truncated packet is treated as a new packet.
- Simultaneous requests: exactly one grant per cycle, chosen by `rr_ptr`.
- Output stall: a beat offered while `out_valid=1` and `slave.t_ready=0` is not accepted and stays on its source.

## Structure
- Shared package `nasti_stream_pkg` holds:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`
  - `localparam MAX_PORT=4`
  - `typedef logic [1:0] port_idx_t`
- Sub-module `nasti_stream_reg_slice` is the single-entry output register with `can_accept`. It is reusable elsewhere in the stream fabric.
- Top level holds:
  - Priority scan: a rotate-by-`rr_ptr` followed by a fixed priority encoder.
  - FSM and grant mux.

## Test plan
- `N_PORT=2`, port 0 sends a 3-beat packet `0x11,0x22,0x33` (last on `0x33`) with `slave.t_ready=1` -> output beats appear on cycles 1..3 after the first accept, in order, with `t_last` only on `0x33`.
- `N_PORT=4`, all ports hold single-beat packets (`t_last=1`) continuously -> output port order is 0,1,2,3,0,… with one beat per cycle.
- `N_PORT=2`, port 0 starts a 4-beat packet, then port 1 asserts valid after beat 1 -> all 4 port-0 beats are output before any port-1 beat; port-1 `t_ready` stays 0 until the cycle after port 0's last accept.
- Output backpressure: `slave.t_ready=0` for 5 cycles mid-packet -> `slave` payload is stable and `t_valid` stays high; no input beats are accepted after the register fills; no beats are lost or duplicated.
- Assert `rst` after beat 2 of a 4-beat packet on port 2 (`rr_ptr=2`) -> `slave.t_valid` drops immediately; all `t_ready=0` during reset; after release, a request on port 0 wins over port 2.
- `N_PORT=1`, random valid/ready toggling over 1000 beats -> output stream equals input stream exactly; `master_1..3.t_ready` stay 0.
